// File: rtl/mercury_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mercury_pkg                                                  |
// | Description : Shared EXU types: ALU op encoding, default tag width and     |
// |               the ALU response record carried towards writeback.          |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mercury_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_op_t;

  localparam int ALU_OP_W  = $bits(alu_op_t);
  localparam int EXU_TAG_W = 6;
  // Wide enough for the largest supported requester count (4).
  localparam int EXU_SRC_W = 2;

  typedef struct packed {
    logic [63:0]          result;
    logic [EXU_TAG_W-1:0] tag;
    logic [EXU_SRC_W-1:0] src;
  } alu_rsp_t;

endpackage : mercury_pkg
`default_nettype wire

// File: rtl/exu_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exu_rr_arb                                                   |
// | Description : Pure combinational round-robin picker. Searches req_i        |
// |               upward from ptr_i with wrap and returns a one-hot grant.     |
// | Ports       : req_i   - request vector                                     |
// |               ptr_i   - index with highest priority this cycle             |
// |               grant_o - one-hot grant (zero when no request)               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exu_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr_i) + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule : exu_rr_arb
`default_nettype wire

// File: rtl/exu_alu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exu_alu_arb                                                  |
// | Description : Shares one combinational EXU ALU among NUM_REQ requesters.   |
// |               Round-robin grant drives the ALU (s0); result and tag are    |
// |               captured into an s1 buffer presented with valid/ready.       |
// | Ports       : clk, rst            - clock, synchronous active-high reset   |
// |               req_valid/ready     - per-requester handshake (ready=grant)  |
// |               req_op/opa/opb/tag  - packed per-requester op fields         |
// |               s0_valid, s0_alu_*  - ALU drive (zero when idle)             |
// |               s0_alu_result       - ALU combinational result               |
// |               rsp_valid/ready     - writeback handshake                    |
// |               rsp_result/tag/src  - buffered response (buffer head)        |
// | Config      : EXU_ALU_ARB_SKID_EN - 2-entry output FIFO, breaks the        |
// |               rsp_ready -> req_ready path. Undefined: 1-entry buffer.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exu_alu_arb
  import mercury_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = EXU_TAG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ALU_OP_W-1:0]   req_op,
  input  logic [NUM_REQ*64-1:0]         req_opa,
  input  logic [NUM_REQ*64-1:0]         req_opb,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  output logic                          s0_valid,
  output logic [ALU_OP_W-1:0]           s0_alu_op,
  output logic [63:0]                   s0_alu_operandA,
  output logic [63:0]                   s0_alu_operandB,
  input  logic [63:0]                   s0_alu_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [63:0]                   rsp_result,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_src
);

  localparam int SRC_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [63:0]      result;
    logic [TAG_W-1:0] tag;
    logic [SRC_W-1:0] src;
  } entry_t;

  logic                accept;
  logic [NUM_REQ-1:0]  req_gated;
  logic [NUM_REQ-1:0]  grant;
  logic [SRC_W-1:0]    gnt_idx;
  logic [TAG_W-1:0]    gnt_tag;
  entry_t              push_entry;
  entry_t              head;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;

  // Masking the requests (rather than the grant) keeps the picker reusable.
  assign req_gated = accept ? req_valid : '0;

  exu_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (SRC_W)
  ) u_rr_arb (
    .req_i   (req_gated),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign s0_valid  = |grant;

  // AND-OR mux on the one-hot grant: every s0 field is zero without a grant,
  // so the shared ALU inputs stay quiet on idle cycles.
  always_comb begin
    s0_alu_op       = '0;
    s0_alu_operandA = '0;
    s0_alu_operandB = '0;
    gnt_tag         = '0;
    gnt_idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        s0_alu_op       |= req_op[i*ALU_OP_W +: ALU_OP_W];
        s0_alu_operandA |= req_opa[i*64 +: 64];
        s0_alu_operandB |= req_opb[i*64 +: 64];
        gnt_tag         |= req_tag[i*TAG_W +: TAG_W];
        gnt_idx         |= SRC_W'(i);
      end
    end
  end

  always_comb begin
    push_entry        = '0;
    push_entry.result = s0_alu_result;
    push_entry.tag    = gnt_tag;
    push_entry.src    = gnt_idx;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (s0_valid) begin
      rr_ptr_d = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef EXU_ALU_ARB_SKID_EN

  entry_t      mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        push;
  logic        pop;

  // Acceptance depends only on registered occupancy.
  assign accept = (count_q != 2'd2);
  assign push   = s0_valid;
  assign pop    = (count_q != 2'd0) && rsp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_valid = (count_q != 2'd0);

`else

  logic   valid_q, valid_d;
  entry_t entry_q, entry_d;

  // A firing response frees the slot in the same cycle, hence the
  // combinational rsp_ready -> req_ready path.
  assign accept = !valid_q || rsp_ready;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (s0_valid) begin
      valid_d = 1'b1;
      entry_d = push_entry;
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign head      = entry_q;
  assign rsp_valid = valid_q;

`endif

  assign rsp_result = head.result;
  assign rsp_tag    = head.tag;
  assign rsp_src    = head.src;

endmodule : exu_alu_arb
`default_nettype wire

// File: tb/tb_exu_alu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_exu_alu_arb                                               |
// | Description : Self-checking bench for exu_alu_arb with a queue-based       |
// |               reference model and a behavioural ALU on the s0 port.        |
// | Config      : EXU_ALU_ARB_SKID_EN selects the 2-entry buffer expectations. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_exu_alu_arb;
  import mercury_pkg::*;

  localparam int N  = 2;
  localparam int TW = EXU_TAG_W;
  localparam int SW = $clog2(N);
`ifdef EXU_ALU_ARB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N*ALU_OP_W-1:0]  req_op;
  logic [N*64-1:0]        req_opa;
  logic [N*64-1:0]        req_opb;
  logic [N*TW-1:0]        req_tag;
  logic                   s0_valid;
  logic [ALU_OP_W-1:0]    s0_alu_op;
  logic [63:0]            s0_alu_operandA;
  logic [63:0]            s0_alu_operandB;
  logic [63:0]            s0_alu_result;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [63:0]            rsp_result;
  logic [TW-1:0]          rsp_tag;
  logic [SW-1:0]          rsp_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exu_alu_arb #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_opa         (req_opa),
    .req_opb         (req_opb),
    .req_tag         (req_tag),
    .s0_valid        (s0_valid),
    .s0_alu_op       (s0_alu_op),
    .s0_alu_operandA (s0_alu_operandA),
    .s0_alu_operandB (s0_alu_operandB),
    .s0_alu_result   (s0_alu_result),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_tag         (rsp_tag),
    .rsp_src         (rsp_src)
  );

  function automatic logic [63:0] alu_model(input logic [ALU_OP_W-1:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[5:0];
      ALU_SRL: return a >> b[5:0];
      ALU_SRA: return $unsigned($signed(a) >>> b[5:0]);
      default: return 64'd0;
    endcase
  endfunction

  // Stand-in for the external exu_alu.
  always_comb s0_alu_result = alu_model(s0_alu_op, s0_alu_operandA, s0_alu_operandB);

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0]   result;
    logic [TW-1:0] tag;
    int            src;
  } exp_t;

  exp_t mq[$];
  int   m_ptr = 0;

  function automatic logic [ALU_OP_W-1:0] lane_op(input int i);
    return req_op[i*ALU_OP_W +: ALU_OP_W];
  endfunction
  function automatic logic [63:0] lane_a(input int i);
    return req_opa[i*64 +: 64];
  endfunction
  function automatic logic [63:0] lane_b(input int i);
    return req_opb[i*64 +: 64];
  endfunction
  function automatic logic [TW-1:0] lane_tag(input int i);
    return req_tag[i*TW +: TW];
  endfunction

  // Requester the arbiter should grant right now, or -1.
  function automatic int exp_grant();
    bit acc;
    if (CAP == 1) acc = (mq.size() == 0) || (rsp_ready == 1'b1);
    else          acc = (mq.size() < CAP);
    if (!acc) return -1;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (m_ptr + off) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic set_lane(input int i, input logic v, input logic [ALU_OP_W-1:0] op,
                          input logic [63:0] a, input logic [63:0] b, input logic [TW-1:0] t);
    req_valid[i]                   = v;
    req_op[i*ALU_OP_W +: ALU_OP_W] = op;
    req_opa[i*64 +: 64]            = a;
    req_opb[i*64 +: 64]            = b;
    req_tag[i*TW +: TW]            = t;
  endtask

  task automatic clear_lanes();
    req_valid = '0;
    req_op    = '0;
    req_opa   = '0;
    req_opb   = '0;
    req_tag   = '0;
  endtask

  // Advance one clock and update the model exactly as the rules dictate.
  task automatic tick();
    int   g;
    exp_t e;
    g = exp_grant();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ptr = 0;
    end else begin
      if (mq.size() > 0 && rsp_ready) void'(mq.pop_front());
      if (g >= 0) begin
        e.result = alu_model(lane_op(g), lane_a(g), lane_b(g));
        e.tag    = lane_tag(g);
        e.src    = g;
        mq.push_back(e);
        m_ptr = (g + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    clear_lanes();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_lanes();
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_result !== 64'd0 || rsp_tag !== '0 || rsp_src !== '0) begin
      errors++; $display("FAIL reset_fields: got result=%h tag=%h src=%h expected all 0", rsp_result, rsp_tag, rsp_src);
    end
    checks++;
    if (req_ready !== '0 || s0_valid !== 1'b0 || s0_alu_operandA !== 64'd0 || s0_alu_op !== '0) begin
      errors++; $display("FAIL reset_idle_s0: got ready=%b s0v=%b a=%h op=%h expected zeros", req_ready, s0_valid, s0_alu_operandA, s0_alu_op);
    end
  endtask

  task automatic test_single();
    clear_lanes();
    rsp_ready = 1'b1;
    set_lane(0, 1'b1, ALU_ADD, 64'd5, 64'd7, TW'(3));
    #1;
    checks++;
    if (req_ready !== 2'b01 || s0_valid !== 1'b1) begin
      errors++; $display("FAIL single_ready: got ready=%b s0v=%b expected 01/1", req_ready, s0_valid);
    end
    checks++;
    if (s0_alu_operandA !== 64'd5 || s0_alu_operandB !== 64'd7 || s0_alu_op !== ALU_ADD) begin
      errors++; $display("FAIL single_s0: got op=%h a=%h b=%h expected ADD 5 7", s0_alu_op, s0_alu_operandA, s0_alu_operandB);
    end
    tick();
    clear_lanes();
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'd12 || rsp_tag !== TW'(3) || rsp_src !== SW'(0)) begin
      errors++; $display("FAIL single_rsp: got v=%b res=%0d tag=%0d src=%0d expected 1 12 3 0", rsp_valid, rsp_result, rsp_tag, rsp_src);
    end
    drain();
  endtask

  task automatic test_contention();
    logic [N-1:0] want;
    do_reset();
    rsp_ready = 1'b1;
    set_lane(0, 1'b1, ALU_ADD, 64'd10, 64'd1, TW'(10));
    set_lane(1, 1'b1, ALU_SUB, 64'd20, 64'd1, TW'(20));
    for (int c = 0; c < 4; c++) begin
      #1;
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (req_ready !== want) begin
        errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", c, req_ready, want);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_src !== SW'(c % 2)) begin
        errors++; $display("FAIL contention_src[%0d]: got v=%b src=%0d expected 1 %0d", c, rsp_valid, rsp_src, c % 2);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int grants;
    do_reset();
    rsp_ready = 1'b0;
    set_lane(0, 1'b1, ALU_XOR, 64'hF0, 64'hFF, TW'(5));
    tick();
    set_lane(0, 1'b1, ALU_ADD, 64'd1, 64'd2, TW'(6));
    set_lane(1, 1'b1, ALU_OR, 64'd4, 64'd8, TW'(7));
    grants = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (req_ready !== '0) grants++;
      checks++;
      if (req_ready !== onehot(exp_grant())) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, req_ready, onehot(exp_grant()));
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 64'h0F || rsp_tag !== TW'(5)) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b res=%h tag=%0d expected 1 0f 5", c, rsp_valid, rsp_result, rsp_tag);
      end
    end
    checks++;
    if (grants !== ((CAP == 2) ? 1 : 0)) begin
      errors++; $display("FAIL bp_grant_count: got %0d expected %0d", grants, (CAP == 2) ? 1 : 0);
    end
    drain();
  endtask

  task automatic test_fire_replace();
    do_reset();
    rsp_ready = 1'b0;
    set_lane(0, 1'b1, ALU_ADD, 64'd1, 64'd1, TW'(1));
    tick();
    clear_lanes();
    set_lane(1, 1'b1, ALU_AND, 64'hC, 64'hA, TW'(9));
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL replace_ready: got %b expected 10", req_ready);
    end
    tick();
    clear_lanes();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'h8 || rsp_tag !== TW'(9) || rsp_src !== SW'(1)) begin
      errors++; $display("FAIL replace_rsp: got v=%b res=%h tag=%0d src=%0d expected 1 8 9 1", rsp_valid, rsp_result, rsp_tag, rsp_src);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    clear_lanes();
    rsp_ready = 1'b0;
    set_lane(0, 1'b1, ALU_OR, 64'd3, 64'd4, TW'(2));
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'd7) begin
      errors++; $display("FAIL rstmid_pre: got v=%b res=%h expected 1 7", rsp_valid, rsp_result);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 64'd0) begin
      errors++; $display("FAIL rstmid_post: got v=%b res=%h expected 0 0", rsp_valid, rsp_result);
    end
    set_lane(0, 1'b1, ALU_ADD, 64'd2, 64'd2, TW'(1));
    set_lane(1, 1'b1, ALU_ADD, 64'd3, 64'd3, TW'(2));
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rstmid_ptr: got %b expected 01", req_ready);
    end
    drain();
  endtask

  task automatic test_overflow();
    clear_lanes();
    rsp_ready = 1'b1;
    set_lane(1, 1'b1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, TW'(63));
    #1;
    checks++;
    if (req_ready !== onehot(exp_grant()) || req_ready === '0) begin
      errors++; $display("FAIL ovf_ready: got %b expected %b", req_ready, onehot(exp_grant()));
    end
    tick();
    clear_lanes();
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'd0 || rsp_src !== SW'(1) || rsp_tag !== TW'(63)) begin
      errors++; $display("FAIL ovf_rsp: got v=%b res=%h src=%0d tag=%0d expected 1 0 1 63", rsp_valid, rsp_result, rsp_src, rsp_tag);
    end
    drain();
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        set_lane(i, 1'($urandom_range(0, 1)), ALU_OP_W'($urandom_range(0, 7)),
                 {$urandom, $urandom}, {$urandom, $urandom}, TW'($urandom));
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 49) == 0);
      #1;
      g = exp_grant();
      checks++;
      if (req_ready !== onehot(g) || s0_valid !== (g >= 0)) begin
        errors++; $display("FAIL rnd_grant[%0d]: got ready=%b s0v=%b expected %b", c, req_ready, s0_valid, onehot(g));
      end
      checks++;
      if (g >= 0) begin
        if (s0_alu_op !== lane_op(g) || s0_alu_operandA !== lane_a(g) || s0_alu_operandB !== lane_b(g)) begin
          errors++; $display("FAIL rnd_s0[%0d]: got op=%h a=%h b=%h expected lane %0d", c, s0_alu_op, s0_alu_operandA, s0_alu_operandB, g);
        end
      end else if (s0_alu_op !== '0 || s0_alu_operandA !== 64'd0 || s0_alu_operandB !== 64'd0) begin
        errors++; $display("FAIL rnd_s0_idle[%0d]: got op=%h a=%h b=%h expected zeros", c, s0_alu_op, s0_alu_operandA, s0_alu_operandB);
      end
      tick();
      rst = 1'b0;
      checks++;
      if (rsp_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b expected %0d", c, rsp_valid, mq.size() > 0);
      end else if (mq.size() > 0) begin
        checks++;
        if (rsp_result !== mq[0].result || rsp_tag !== mq[0].tag || rsp_src !== SW'(mq[0].src)) begin
          errors++; $display("FAIL rnd_head[%0d]: got res=%h tag=%h src=%0d expected res=%h tag=%h src=%0d",
                             c, rsp_result, rsp_tag, rsp_src, mq[0].result, mq[0].tag, mq[0].src);
        end
      end
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    clear_lanes();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_fire_replace();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule : tb_exu_alu_arb
`default_nettype wire
